rom_read_sequencer: RTL and testbench

Upstream stage of the address display. Walks a parallel ROM chip through addresses 0..LAST_ADDRESS. For each address it:
- drives chip-select and output-enable,
- waits the access time,
- captures the data byte and hands it downstream over a valid/ready handshake,
- dwells on the address so the 3-digit display can show it.

rom_address feeds the display's address_line directly.

---
 rtl/rom_reader_pkg.sv | 24 ++
 rtl/rom_read_sequencer_if.sv | 38 +++
 rtl/rom_read_sequencer_wait_timer.sv | 27 ++
 rtl/rom_read_sequencer.sv | 135 +++++++++++++
 tb/tb_rom_read_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_reader_pkg.sv
// Shared types and constants for the ROM reader and the address display.
// Holds the sequencer state encoding and default bus widths.
package rom_reader_pkg;

  localparam int ADDR_WIDTH_DEF = 9;
  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    ACCESS  = 3'd2,
    HANDOFF = 3'd3,
    HOLD    = 3'd4,
    DONE    = 3'd5
  } state_t;

  // Bits needed to hold the larger of two cycle counts.
  function automatic int timer_bits(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rom_read_sequencer_if.sv
// ROM bus and downstream byte stream of the ROM read sequencer.
// master = sequencer side, slave = ROM plus downstream consumer.
interface rom_read_sequencer_if
  import rom_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

  logic [ADDR_WIDTH-1:0] rom_address;
  logic                  rom_cs_n;
  logic                  rom_oe_n;
  logic [DATA_WIDTH-1:0] rom_data;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  data_ready;

  modport master (
    output rom_address,
    output rom_cs_n,
    output rom_oe_n,
    input  rom_data,
    output data_out,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  rom_address,
    input  rom_cs_n,
    input  rom_oe_n,
    output rom_data,
    input  data_out,
    input  data_valid,
    output data_ready
  );

endinterface

// File: rtl/rom_read_sequencer_wait_timer.sv
// Loadable down-counter shared by the access and dwell phases.
// Stops at zero; expired is flagged while the count is zero.
module wait_timer #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/rom_read_sequencer.sv
// Walks a parallel ROM from address 0 to LAST_ADDRESS, hands each byte
// downstream over valid/ready and dwells so the display can show it.
module rom_read_sequencer
  import rom_reader_pkg::*;
#(
  parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int LAST_ADDRESS  = 511,
  parameter int ACCESS_CYCLES = 10,
  parameter int HOLD_CYCLES   = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic abort,
  rom_read_sequencer_if.master bus,
  output logic busy,
  output logic done
);

  localparam int TW = timer_bits(ACCESS_CYCLES, HOLD_CYCLES);

  localparam logic [TW-1:0] ACCESS_LOAD =
    TW'(ACCESS_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LOAD =
    TW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(LAST_ADDRESS);
  localparam bit NO_DWELL = (HOLD_CYCLES == 0);

  state_t                state;
  logic [ADDR_WIDTH-1:0] address;
  logic                  cs_n;
  logic                  oe_n;
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;

  logic                  expired;
  logic                  handshake;
  logic                  hold_exit;
  logic                  timer_load;
  logic [TW-1:0]         timer_value;

  assign handshake = (state == HANDOFF) && valid
                   && bus.data_ready;

  // With no dwell the address advances on the handshake edge itself.
  assign hold_exit = ((state == HOLD) && expired)
                   || (handshake && NO_DWELL);

  assign timer_load  = (state == SETUP) || handshake;
  assign timer_value = (state == SETUP) ? ACCESS_LOAD : HOLD_LOAD;

  wait_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (timer_load),
    .load_value(timer_value),
    .expired   (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      address <= '0;
      cs_n    <= 1'b1;
      oe_n    <= 1'b1;
      data    <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      cs_n  <= 1'b1;
      oe_n  <= 1'b1;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= SETUP;
            address <= '0;
            cs_n    <= 1'b0;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        SETUP: begin
          state <= ACCESS;
          oe_n  <= 1'b0;
        end
        ACCESS: begin
          if (expired) begin
            data  <= bus.rom_data;
            valid <= 1'b1;
            oe_n  <= 1'b1;
            cs_n  <= 1'b1;
            state <= HANDOFF;
          end
        end
        HANDOFF: begin
          if (bus.data_ready) begin
            valid <= 1'b0;
            state <= HOLD;
          end
        end
        HOLD: state <= HOLD;
        default: state <= IDLE;
      endcase

      if (hold_exit) begin
        if (address == LAST) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          address <= address + ADDR_WIDTH'(1);
          state   <= SETUP;
          cs_n    <= 1'b0;
        end
      end
    end
  end

  assign bus.rom_address = address;
  assign bus.rom_cs_n    = cs_n;
  assign bus.rom_oe_n    = oe_n;
  assign bus.data_out    = data;
  assign bus.data_valid  = valid;

endmodule

// File: tb/tb_rom_read_sequencer.sv
// Scoreboard bench for rom_read_sequencer: a main instance with a short
// scan and a second one with no dwell and a single address.
module tb_rom_read_sequencer;

  localparam int AW = 9;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic start2 = 1'b0;
  logic abort2 = 1'b0;
  logic busy, done, busy2, done2;

  int checks = 0;
  int passes = 0;
  int xfers = 0;
  int xfers2 = 0;
  logic [7:0] sb[$];
  logic [7:0] sb2[$];

  rom_read_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  rom_read_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus2 ();

  assign bus.rom_data  = 8'(bus.rom_address) ^ 8'hA5;
  assign bus2.rom_data = 8'(bus2.rom_address) ^ 8'hA5;

  always #5 clk = ~clk;

  rom_read_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LAST_ADDRESS(3),
    .ACCESS_CYCLES(3), .HOLD_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .bus(bus.master), .busy(busy), .done(done)
  );

  rom_read_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LAST_ADDRESS(0),
    .ACCESS_CYCLES(3), .HOLD_CYCLES(0)
  ) dut2 (
    .clk(clk), .reset(reset), .start(start2), .abort(abort2),
    .bus(bus2.master), .busy(busy2), .done(done2)
  );

  // {cs_n, oe_n, valid, busy, done}
  function automatic logic [4:0] st1();
    return {bus.rom_cs_n, bus.rom_oe_n, bus.data_valid, busy, done};
  endfunction

  function automatic logic [4:0] st2();
    return {bus2.rom_cs_n, bus2.rom_oe_n, bus2.data_valid, busy2, done2};
  endfunction

  // Handshakes are sampled at the falling edge, before the transfer edge.
  task automatic mon();
    logic [7:0] e;
    if (!reset && bus.data_valid && bus.data_ready) begin
      checks++;
      xfers++;
      if (sb.size() == 0) begin
        $display("FAIL xfer: unexpected byte %h", bus.data_out);
      end else begin
        e = sb.pop_front();
        if (bus.data_out !== e)
          $display("FAIL xfer: got %h want %h", bus.data_out, e);
        else passes++;
      end
    end
    if (!reset && bus2.data_valid && bus2.data_ready) begin
      checks++;
      xfers2++;
      if (sb2.size() == 0) begin
        $display("FAIL xfer2: unexpected byte %h", bus2.data_out);
      end else begin
        e = sb2.pop_front();
        if (bus2.data_out !== e)
          $display("FAIL xfer2: got %h want %h", bus2.data_out, e);
        else passes++;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic push_scan();
    for (int a = 0; a < 4; a++) sb.push_back(8'(a) ^ 8'hA5);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_state(input logic [8:0] a, input logic [4:0] s,
                            input string name);
    int n;
    n = 0;
    while (!(bus.rom_address == a && st1() == s) && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (bus.rom_address !== a || st1() !== s)
      $display("FAIL %s: addr %0d st %b want addr %0d st %b",
               name, bus.rom_address, st1(), a, s);
    else passes++;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #3;
    checks++;
    if ({st1(), bus.rom_address, bus.data_out} !== {5'b11000, 9'd0, 8'd0})
      $display("FAIL reset: st %b addr %0d data %h want 11000/0/00",
               st1(), bus.rom_address, bus.data_out);
    else passes++;
    checks++;
    if ({st2(), bus2.rom_address, bus2.data_out} !== {5'b11000, 9'd0, 8'd0})
      $display("FAIL reset2: st %b addr %0d data %h want 11000/0/00",
               st2(), bus2.rom_address, bus2.data_out);
    else passes++;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_scan();
    int x0;
    x0 = xfers;
    bus.data_ready = 1'b1;
    push_scan();
    pulse_start();
    checks++;
    if ({st1(), bus.rom_address} !== {5'b01010, 9'd0})
      $display("FAIL setup: st %b addr %0d want 01010/0",
               st1(), bus.rom_address);
    else passes++;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (st1() !== 5'b00010)
        $display("FAIL access%0d: st %b want 00010", i, st1());
      else passes++;
    end
    tick();
    checks++;
    if ({st1(), bus.data_out} !== {5'b11110, 8'hA5})
      $display("FAIL first_valid: st %b data %h want 11110/a5",
               st1(), bus.data_out);
    else passes++;
    wait_state(9'd3, 5'b11001, "scan_done");
    checks++;
    if (xfers - x0 !== 4 || sb.size() !== 0)
      $display("FAIL scan_count: xfers %0d left %0d want 4/0",
               xfers - x0, sb.size());
    else passes++;
  endtask

  task automatic test_backpressure();
    int x0, x1;
    x0 = xfers;
    push_scan();
    pulse_start();
    wait_state(9'd1, 5'b01010, "bp_addr1");
    bus.data_ready = 1'b0;
    wait_state(9'd1, 5'b11110, "bp_valid");
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({bus.data_valid, bus.data_out, bus.rom_address}
          !== {1'b1, 8'hA4, 9'd1})
        $display("FAIL bp_stall%0d: v %b data %h addr %0d want 1/a4/1",
                 i, bus.data_valid, bus.data_out, bus.rom_address);
      else passes++;
      tick();
    end
    bus.data_ready = 1'b1;
    x1 = xfers;
    tick();
    checks++;
    if (xfers - x1 !== 1 || bus.data_valid !== 1'b0)
      $display("FAIL bp_release: xfers %0d v %b want 1/0",
               xfers - x1, bus.data_valid);
    else passes++;
    wait_state(9'd3, 5'b11001, "bp_done");
    checks++;
    if (xfers - x0 !== 4 || sb.size() !== 0)
      $display("FAIL bp_count: xfers %0d left %0d want 4/0",
               xfers - x0, sb.size());
    else passes++;
  endtask

  task automatic test_abort();
    push_scan();
    pulse_start();
    wait_state(9'd2, 5'b00010, "ab_access2");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({st1(), bus.rom_address} !== {5'b11000, 9'd2})
      $display("FAIL abort: st %b addr %0d want 11000/2",
               st1(), bus.rom_address);
    else passes++;
    checks++;
    if (sb.size() !== 2)
      $display("FAIL abort_left: got %0d want 2", sb.size());
    else passes++;
    sb.delete();
    repeat (3) tick();
    checks++;
    if ({st1(), bus.rom_address} !== {5'b11000, 9'd2})
      $display("FAIL abort_idle: st %b addr %0d want 11000/2",
               st1(), bus.rom_address);
    else passes++;
    push_scan();
    pulse_start();
    checks++;
    if ({st1(), bus.rom_address} !== {5'b01010, 9'd0})
      $display("FAIL rescan: st %b addr %0d want 01010/0",
               st1(), bus.rom_address);
    else passes++;
    wait_state(9'd3, 5'b11001, "rescan_done");
  endtask

  task automatic test_start_ignored();
    int x0;
    x0 = xfers;
    push_scan();
    pulse_start();
    wait_state(9'd1, 5'b01010, "si_addr1");
    pulse_start();
    checks++;
    if ({busy, bus.rom_address} !== {1'b1, 9'd1})
      $display("FAIL start_busy: busy %b addr %0d want 1/1",
               busy, bus.rom_address);
    else passes++;
    wait_state(9'd3, 5'b11001, "si_done");
    checks++;
    if (xfers - x0 !== 4 || sb.size() !== 0)
      $display("FAIL si_count: xfers %0d left %0d want 4/0",
               xfers - x0, sb.size());
    else passes++;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if ({st1(), bus.rom_address} !== {5'b11000, 9'd3})
      $display("FAIL start_abort_done: st %b addr %0d want 11000/3",
               st1(), bus.rom_address);
    else passes++;
    push_scan();
    pulse_start();
    wait_state(9'd1, 5'b01010, "sa_addr1");
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    sb.delete();
    repeat (2) tick();
    checks++;
    if ({st1(), bus.rom_address} !== {5'b11000, 9'd1})
      $display("FAIL start_abort_busy: st %b addr %0d want 11000/1",
               st1(), bus.rom_address);
    else passes++;
  endtask

  task automatic test_async_reset();
    push_scan();
    pulse_start();
    wait_state(9'd1, 5'b11010, "ar_hold1");
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({st1(), bus.rom_address, bus.data_out} !== {5'b11000, 9'd0, 8'd0})
      $display("FAIL async_reset: st %b addr %0d data %h want 11000/0/00",
               st1(), bus.rom_address, bus.data_out);
    else passes++;
    #2 reset = 1'b0;
    sb.delete();
    repeat (3) tick();
    checks++;
    if ({st1(), bus.rom_address} !== {5'b11000, 9'd0})
      $display("FAIL post_reset_idle: st %b addr %0d want 11000/0",
               st1(), bus.rom_address);
    else passes++;
    push_scan();
    pulse_start();
    checks++;
    if ({st1(), bus.rom_address} !== {5'b01010, 9'd0})
      $display("FAIL reset_rescan: st %b addr %0d want 01010/0",
               st1(), bus.rom_address);
    else passes++;
    wait_state(9'd3, 5'b11001, "reset_rescan_done");
  endtask

  task automatic test_no_hold();
    bus2.data_ready = 1'b1;
    sb2.push_back(8'hA5);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    checks++;
    if (st2() !== 5'b01010)
      $display("FAIL nh_setup: st %b want 01010", st2());
    else passes++;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (st2() !== 5'b00010)
        $display("FAIL nh_access%0d: st %b want 00010", i, st2());
      else passes++;
    end
    tick();
    checks++;
    if ({st2(), bus2.data_out} !== {5'b11110, 8'hA5})
      $display("FAIL nh_valid: st %b data %h want 11110/a5",
               st2(), bus2.data_out);
    else passes++;
    tick();
    checks++;
    if ({st2(), bus2.rom_address} !== {5'b11001, 9'd0})
      $display("FAIL nh_done: st %b addr %0d want 11001/0",
               st2(), bus2.rom_address);
    else passes++;
    checks++;
    if (xfers2 !== 1 || sb2.size() !== 0)
      $display("FAIL nh_count: xfers %0d left %0d want 1/0",
               xfers2, sb2.size());
    else passes++;
  endtask

  initial begin
    bus.data_ready  = 1'b0;
    bus2.data_ready = 1'b0;
    test_reset();
    test_scan();
    test_backpressure();
    test_abort();
    test_start_ignored();
    test_async_reset();
    test_no_hold();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
